// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the RV32M issue controller: funct3 encodings of the
// M-extension operations, the controller state type and small predicates that
// classify an operation (divide vs multiply, which operands are signed).
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Divide and remainder operations all live in the upper half of funct3.
  function automatic logic is_div(input logic [2:0] funct3);
    return funct3[2];
  endfunction

  // rs1 is treated as two's complement for every op except MULHU, DIVU, REMU.
  function automatic logic is_signed_a(input logic [2:0] funct3);
    logic res;
    case (funct3)
      F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM: res = 1'b1;
      default:                                    res = 1'b0;
    endcase
    return res;
  endfunction

  // rs2 is signed only for MUL, MULH, DIV and REM; MULHSU takes it unsigned.
  function automatic logic is_signed_b(input logic [2:0] funct3);
    logic res;
    case (funct3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: res = 1'b1;
      default:                         res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/muldiv_sign.sv
// muldiv_sign
// Purely combinational sign handling around the unsigned multiply/divide units.
// Issue side: turns rs1/rs2 into unsigned magnitudes plus sign flags for the
// operation being issued. Completion side: applies the sign correction to the
// unsigned unit result for the latched operation and selects the rd word.
// Ports:
//   issue_op, rs1, rs2      operation and raw operands at issue time
//   a_mag, b_mag            operand magnitudes (raw value when unsigned)
//   a_neg, b_neg            operand is signed and negative
//   op, sa, sb              latched operation and operand signs
//   mul_result, div_result  unsigned unit results (div: {rem, quot})
//   result                  sign-corrected XLEN-bit rd value
module muldiv_sign
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        issue_op,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  output logic [XLEN-1:0]   a_mag,
  output logic [XLEN-1:0]   b_mag,
  output logic              a_neg,
  output logic              b_neg,
  input  logic [2:0]        op,
  input  logic              sa,
  input  logic              sb,
  input  logic [2*XLEN-1:0] mul_result,
  input  logic [2*XLEN-1:0] div_result,
  output logic [XLEN-1:0]   result
);

  logic              prod_neg;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   quotient;
  logic [XLEN-1:0]   remainder;

  // Magnitude extraction. The most negative value negates to itself, which is
  // still the correct unsigned magnitude, so no special handling is needed.
  always_comb begin
    a_neg = is_signed_a(issue_op) & rs1[XLEN-1];
    b_neg = is_signed_b(issue_op) & rs2[XLEN-1];
    a_mag = a_neg ? -rs1 : rs1;
    b_mag = b_neg ? -rs2 : rs2;
  end

  // Result correction. The whole double-width product is negated before the
  // word is picked so that the high word of a signed product comes out right.
  // sa/sb are already zero for unsigned operands, but the per-op selection of
  // the negate condition is kept explicit.
  always_comb begin
    prod_neg = 1'b0;
    case (op)
      F3_MUL, F3_MULH: prod_neg = sa ^ sb;
      F3_MULHSU:       prod_neg = sa;
      default:         prod_neg = 1'b0;
    endcase
    product   = prod_neg ? -mul_result : mul_result;
    quotient  = div_result[XLEN-1:0];
    remainder = div_result[2*XLEN-1:XLEN];
    result    = '0;
    case (op)
      F3_MUL:                      result = product[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result = product[2*XLEN-1:XLEN];
      F3_DIV:                      result = (sa ^ sb) ? -quotient : quotient;
      F3_DIVU:                     result = quotient;
      F3_REM:                      result = sa ? -remainder : remainder;
      F3_REMU:                     result = remainder;
      default:                     result = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
// EX-stage issue/sequencing controller for RV32M. Accepts an M-type op, hands
// unsigned operand magnitudes to the multiply or divide unit through a level
// req / one-cycle ready handshake, stalls the pipeline meanwhile, then applies
// sign correction (or the divide-by-zero / overflow rules) and presents rd for
// one cycle with done_o.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   valid_i, flush_i             op present in EX / squash in-flight op
//   funct3_i, rs1_i, rs2_i       operation select and source operands
//   stall_o                      freeze upstream pipeline
//   done_o, rd_o                 one-cycle completion pulse and result
//   mul_req_o, div_req_o         level requests to the units
//   a_o, b_o                     unsigned operand magnitudes for the unit
//   mul_ready_i, div_ready_i     one-cycle unit completion
//   mul_result_i, div_result_i   unit results (div: {rem, quot})
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [XLEN-1:0]   rd_o,
  output logic              mul_req_o,
  output logic              div_req_o,
  output logic [XLEN-1:0]   a_o,
  output logic [XLEN-1:0]   b_o,
  input  logic              mul_ready_i,
  input  logic              div_ready_i,
  input  logic [2*XLEN-1:0] mul_result_i,
  input  logic [2*XLEN-1:0] div_result_i
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q, state_n;
  logic [2:0]      op_q;
  logic            sa_q, sb_q;
  logic [XLEN-1:0] a_q, b_q, rd_q;
  logic            done_q, done_n;
  logic            mul_req_q, mul_req_n;
  logic            div_req_q, div_req_n;

  logic            accept, capture_special, capture_unit;
  logic            unit_answered;
  logic [XLEN-1:0] a_mag, b_mag, unit_rd;
  logic            a_neg, b_neg;

  logic            div_by_zero, signed_ovf, special_hit;
  logic [XLEN-1:0] special_rd;

  muldiv_sign #(.XLEN(XLEN)) u_sign (
    .issue_op   (funct3_i),
    .rs1        (rs1_i),
    .rs2        (rs2_i),
    .a_mag      (a_mag),
    .b_mag      (b_mag),
    .a_neg      (a_neg),
    .b_neg      (b_neg),
    .op         (op_q),
    .sa         (sa_q),
    .sb         (sb_q),
    .mul_result (mul_result_i),
    .div_result (div_result_i),
    .result     (unit_rd)
  );

  // Ops whose answer is fixed by the RISC-V rules never reach a unit: divide
  // by zero for any divide op, and the single signed overflow case.
  always_comb begin
    div_by_zero = is_div(funct3_i) && (rs2_i == '0);
    signed_ovf  = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
                  (rs1_i == INT_MIN) && (rs2_i == '1);
    special_hit = div_by_zero || signed_ovf;
    special_rd  = '0;
    if (div_by_zero) begin
      special_rd = ((funct3_i == F3_REM) || (funct3_i == F3_REMU)) ? rs1_i : '1;
    end else if (signed_ovf) begin
      special_rd = (funct3_i == F3_REM) ? '0 : INT_MIN;
    end
  end

  // Only the ready of the unit we actually asked counts; anything arriving
  // without an outstanding request is ignored.
  assign unit_answered = (mul_req_q & mul_ready_i) | (div_req_q & div_ready_i);

  // Next-state logic. Requests and done are computed here and registered, so
  // they follow the state they belong to. Flush overrides everything,
  // including a ready arriving in the same cycle.
  always_comb begin
    state_n         = state_q;
    mul_req_n       = 1'b0;
    div_req_n       = 1'b0;
    done_n          = 1'b0;
    accept          = 1'b0;
    capture_special = 1'b0;
    capture_unit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          accept = 1'b1;
          if (special_hit) begin
            state_n         = ST_DONE;
            done_n          = 1'b1;
            capture_special = 1'b1;
          end else begin
            state_n   = ST_REQ;
            mul_req_n = ~is_div(funct3_i);
            div_req_n = is_div(funct3_i);
          end
        end
      end
      ST_REQ: begin
        if (unit_answered) begin
          state_n      = ST_DONE;
          done_n       = 1'b1;
          capture_unit = 1'b1;
        end else begin
          mul_req_n = mul_req_q;
          div_req_n = div_req_q;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    if (flush_i) begin
      state_n         = ST_IDLE;
      mul_req_n       = 1'b0;
      div_req_n       = 1'b0;
      done_n          = 1'b0;
      accept          = 1'b0;
      capture_special = 1'b0;
      capture_unit    = 1'b0;
    end
  end

  // State and datapath registers. Operands are latched once at acceptance so
  // a_o/b_o stay stable for the whole request; rd holds until the next capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      op_q      <= F3_MUL;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      done_q    <= 1'b0;
      mul_req_q <= 1'b0;
      div_req_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      done_q    <= done_n;
      mul_req_q <= mul_req_n;
      div_req_q <= div_req_n;
      if (flush_i) begin
        a_q <= '0;
        b_q <= '0;
      end else if (accept) begin
        op_q <= funct3_i;
        sa_q <= a_neg;
        sb_q <= b_neg;
        a_q  <= a_mag;
        b_q  <= b_mag;
      end
      if (capture_special) begin
        rd_q <= special_rd;
      end else if (capture_unit) begin
        rd_q <= unit_rd;
      end
    end
  end

  // The pipeline is released in DONE so it advances at the end of that cycle.
  assign stall_o   = valid_i & ~flush_i & (state_q != ST_DONE);
  assign done_o    = done_q;
  assign rd_o      = rd_q;
  assign mul_req_o = mul_req_q;
  assign div_req_o = div_req_q;
  assign a_o       = a_q;
  assign b_o       = b_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl
// Scoreboard bench for muldiv_ctrl. The driver issues ops and pushes the
// expected rd and completion latency from a plain-arithmetic RV32M model; a
// monitor pops and compares on every done_o. A behavioural unit model answers
// requests after a chosen delay and checks operand stability while it waits.
module tb_muldiv_ctrl;

  localparam int XLEN = 32;

  logic              clk_i = 1'b0;
  logic              rst_i, valid_i, flush_i;
  logic [2:0]        funct3_i;
  logic [XLEN-1:0]   rs1_i, rs2_i;
  logic              stall_o, done_o, mul_req_o, div_req_o;
  logic [XLEN-1:0]   rd_o, a_o, b_o;
  logic              mul_ready_i, div_ready_i;
  logic [2*XLEN-1:0] mul_result_i, div_result_i;

  muldiv_ctrl #(.XLEN(XLEN)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .flush_i      (flush_i),
    .funct3_i     (funct3_i),
    .rs1_i        (rs1_i),
    .rs2_i        (rs2_i),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .rd_o         (rd_o),
    .mul_req_o    (mul_req_o),
    .div_req_o    (div_req_o),
    .a_o          (a_o),
    .b_o          (b_o),
    .mul_ready_i  (mul_ready_i),
    .div_ready_i  (div_ready_i),
    .mul_result_i (mul_result_i),
    .div_result_i (div_result_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rd;
    int          lat;
    int          issue;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          unit_en = 1'b1;
  int          unit_delay = 0;
  logic [31:0] exp_a, exp_b;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
    end
  endtask

  // RV32M reference: signed products via sign-extended 64-bit arithmetic,
  // division via SystemVerilog signed/unsigned operators plus the ISA rules.
  function automatic logic [31:0] ref_rd(input logic [2:0] f3, input logic [31:0] x,
                                         input logic [31:0] y);
    logic [63:0] sx, sy, ux, uy, p;
    logic [31:0] r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    r  = '0;
    case (f3)
      3'd0: begin p = sx * sy; r = p[31:0];  end
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * uy; r = p[63:32]; end
      3'd3: begin p = ux * uy; r = p[63:32]; end
      3'd4: begin
        if (y == 0) r = 32'hFFFF_FFFF;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = x;
        else r = $signed(x) / $signed(y);
      end
      3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) r = x;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
        else r = $signed(x) % $signed(y);
      end
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] magnitude(input logic [31:0] v, input bit signed_op);
    if (signed_op && $signed(v) < 0) return -v;
    return v;
  endfunction

  // Unit model: answers a request after unit_delay extra cycles with the true
  // unsigned product or {remainder, quotient} of the operands it was given.
  initial begin
    logic        is_mul;
    logic [31:0] a0, b0;
    mul_ready_i  = 1'b0;
    div_ready_i  = 1'b0;
    mul_result_i = '0;
    div_result_i = '0;
    forever begin
      @(negedge clk_i);
      if (unit_en && (mul_req_o || div_req_o)) begin
        is_mul = mul_req_o;
        a0 = a_o;
        b0 = b_o;
        checkOutput("unit_a", a0, exp_a);
        checkOutput("unit_b", b0, exp_b);
        for (int k = 0; k < unit_delay; k++) begin
          @(negedge clk_i);
          checkOutput("hold_req", 32'({mul_req_o, div_req_o}), 32'({is_mul, ~is_mul}));
          checkOutput("hold_a", a_o, a0);
          checkOutput("hold_b", b_o, b0);
          checkOutput("hold_stall", 32'(stall_o), 32'd1);
        end
        if (is_mul) begin
          mul_result_i = {32'd0, a0} * {32'd0, b0};
          mul_ready_i  = 1'b1;
        end else begin
          div_result_i = (b0 == 0) ? {a0, 32'hFFFF_FFFF} : {a0 % b0, a0 / b0};
          div_ready_i  = 1'b1;
        end
        @(negedge clk_i);
        mul_ready_i = 1'b0;
        div_ready_i = 1'b0;
        checkOutput("req_drop", 32'({mul_req_o, div_req_o}), 32'd0);
      end
    end
  end

  // Monitor: every done_o must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (done_o === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: done_o=1, expected 0 with no op outstanding");
        end else begin
          e = sb_q.pop_front();
          checkOutput("rd", rd_o, e.rd);
          checkOutput("latency", 32'(cyc - e.issue + 1), 32'(e.lat));
        end
      end
    end
  end

  // Issue one op, keep valid_i high (as a stalled pipeline would) until done.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] x,
                               input logic [31:0] y, input int delay);
    exp_t e;
    bit   special, saw_req, seen_done;
    special = f3[2] && ((y == 0) ||
              (!f3[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    @(posedge clk_i);
    #1;
    funct3_i   = f3;
    rs1_i      = x;
    rs2_i      = y;
    valid_i    = 1'b1;
    exp_a      = magnitude(x, f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6});
    exp_b      = magnitude(y, f3 inside {3'd0, 3'd1, 3'd4, 3'd6});
    unit_delay = delay;
    e.rd    = ref_rd(f3, x, y);
    e.lat   = special ? 2 : 3 + delay;
    e.issue = cyc;
    sb_q.push_back(e);
    saw_req   = 1'b0;
    seen_done = 1'b0;
    for (int k = 1; k <= 40 && !seen_done; k++) begin
      @(negedge clk_i);
      if (mul_req_o || div_req_o) saw_req = 1'b1;
      checkOutput("stall", 32'(stall_o), 32'(k != e.lat));
      if (done_o) seen_done = 1'b1;
    end
    if (!seen_done) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: no done_o within 40 cycles, expected one");
    end
    if (special) checkOutput("no_req_special", 32'(saw_req), 32'd0);
  endtask

  task automatic idleGap(input int n);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    repeat (n) @(posedge clk_i);
  endtask

  // Squash a MUL while its request is outstanding, then deliver a late ready.
  task automatic abortTest(input bit use_reset);
    @(posedge clk_i);
    #1;
    unit_en  = 1'b0;
    funct3_i = 3'd0;
    rs1_i    = 32'd3;
    rs2_i    = 32'd5;
    valid_i  = 1'b1;
    repeat (2) @(negedge clk_i);
    checkOutput("abort_req_up", 32'(mul_req_o), 32'd1);
    if (use_reset) begin
      rst_i = 1'b1;
    end else begin
      flush_i      = 1'b1;
      mul_ready_i  = 1'b1;
      mul_result_i = 64'd15;
      #1;
      checkOutput("flush_stall", 32'(stall_o), 32'd0);
    end
    @(posedge clk_i);
    #1;
    rst_i       = 1'b0;
    flush_i     = 1'b0;
    valid_i     = 1'b0;
    mul_ready_i = 1'b0;
    @(negedge clk_i);
    checkOutput("abort_done", 32'(done_o), 32'd0);
    checkOutput("abort_reqs", 32'({mul_req_o, div_req_o}), 32'd0);
    checkOutput("abort_stall", 32'(stall_o), 32'd0);
    checkOutput("abort_a", a_o, 32'd0);
    checkOutput("abort_b", b_o, 32'd0);
    if (use_reset) checkOutput("abort_rd", rd_o, 32'd0);
    mul_ready_i  = 1'b1;
    mul_result_i = 64'd15;
    @(negedge clk_i);
    mul_ready_i = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      checkOutput("late_ready_done", 32'(done_o), 32'd0);
      checkOutput("late_ready_req", 32'({mul_req_o, div_req_o}), 32'd0);
    end
    unit_en = 1'b1;
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] x, y;
    int          sel;
    rst_i    = 1'b1;
    valid_i  = 1'b0;
    flush_i  = 1'b0;
    funct3_i = 3'd0;
    rs1_i    = '0;
    rs2_i    = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("reset_stall", 32'(stall_o), 32'd0);
    checkOutput("reset_done", 32'(done_o), 32'd0);
    checkOutput("reset_reqs", 32'({mul_req_o, div_req_o}), 32'd0);
    checkOutput("reset_rd", rd_o, 32'd0);
    checkOutput("reset_a", a_o, 32'd0);
    checkOutput("reset_b", b_o, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 1);
    applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, 2);
    idleGap(1);
    applyStimulus(3'd5, 32'd5, 32'd0, 0);
    applyStimulus(3'd6, 32'd5, 32'd0, 0);
    applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(3'd3, 32'hFFFF_FFFF, 32'd2, 5);
    idleGap(1);
    abortTest(1'b1);
    abortTest(1'b0);
    applyStimulus(3'd0, 32'd6, 32'd7, 0);

    for (int i = 0; i < 80; i++) begin
      f3  = 3'($urandom_range(0, 7));
      x   = $urandom;
      y   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) y = 32'd0;
      else if (sel == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      else if (sel == 2) y = 32'($urandom_range(1, 5));
      applyStimulus(f3, x, y, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idleGap(1);
    end

    idleGap(3);
    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Issue/sequencing controller for the RV32M extension in the EX stage. It is the initiating end of the `req`/`ready` handshake that the multiply and divide units answer. It decodes funct3, reduces signed operands to unsigned magnitudes, requests the selected unit, and stalls the pipeline until the unit answers. It then applies sign correction and the RISC-V divide-by-zero and overflow rules, and presents the final `rd` value for one cycle.

## Interface
- `XLEN`, 32, datapath width; unit results are `2*XLEN` wide.
- `clk_i`  in  1  clock, all state on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `valid_i`  in  1  M-type instruction present in EX; held stable by the pipeline while `stall_o`.
- `flush_i`  in  1  squash the in-flight operation.
- `funct3_i`  in  3  M-op select.
- `rs1_i`, `rs2_i`  in  XLEN  source operands.
- `stall_o`  out  1  freeze the upstream pipeline.
- `done_o`  out  1  one-cycle pulse; `rd_o` valid.
- `rd_o`  out  XLEN  final result.
- `mul_req_o`, `div_req_o`  out  1  level request to the multiply or divide unit.
- `a_o`, `b_o`  out  XLEN  unsigned operand magnitudes for the selected unit.
- `mul_ready_i`, `div_ready_i`  in  1  unit completion, asserted for one cycle.
- `mul_result_i`  in  2*XLEN  unsigned product.
- `div_result_i`  in  2*XLEN  quotient in `[XLEN-1:0]`, remainder in `[2*XLEN-1:XLEN]`.

## Operation
- **States.**
  - IDLE: accepts an instruction.
  - REQ: request outstanding to a unit.
  - DONE: result presented.
- **IDLE with `valid_i`.** Latch funct3, operand signs and magnitudes.
  - `a_o` = |rs1| for MULH, MULHSU, MUL, DIV, REM; raw rs1 otherwise.
  - `b_o` = |rs2| for MULH, MUL, DIV, REM; raw rs2 otherwise.
  - Go to REQ, except for the special cases below, which go to DONE with no request.
- **Special cases.**
  - Divide by zero (rs2 = 0, any div op): DIV/DIVU → all ones; REM/REMU → rs1.
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- **REQ.** Hold the request high, with `a_o`/`b_o` stable, until the matching ready is sampled high. On that cycle, capture the corrected result and go to DONE.
- **Sign correction.** Negate the full 2*XLEN product when `neg` is set.
  - MUL: `neg` = sa^sb.
  - MULH: `neg` = sa^sb.
  - MULHSU: `neg` = sa.
  - MUL takes the low word; MULH, MULHSU and MULHU take the high word.
  - Quotient is negated if sa^sb (DIV only).
  - Remainder is negated if sa (REM only).
- **DONE.** `done_o` = 1 and `stall_o` = 0, so the pipeline advances at the end of this cycle. Always go to IDLE.
- **Flush and reset.**
  - `flush_i` or `rst_i` in any state: go to IDLE and drop the request.
  - A ready arriving after the squash is ignored.
  - `flush_i` dominates an arriving ready.
- **Ready in IDLE or DONE.** A ready with no outstanding request is ignored.

## Timing
- **Reset values.** `stall_o`, `done_o`, both requests, `rd_o`, `a_o`, `b_o` are all 0.
- **`stall_o`.** Combinational: `valid_i & ~flush_i & state≠DONE`.
- **Requests.** Registered, asserted from the first REQ cycle.
- **Latency, `valid_i` to `done_o`.**
  - Special case: 2 cycles.
  - Normal: 3 cycles when the unit answers in the first REQ cycle, plus one cycle per extra cycle before ready.
- **Back-to-back.** A new `valid_i` is accepted in the IDLE cycle directly after DONE.
- **Registered outputs.** `rd_o` is registered and held until the next capture; `done_o` is registered.

## Structure
- **`muldiv_pkg`.**
  - funct3 constants: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - `state_t` enum.
  - Helper predicates `is_div`, `is_signed_a`, `is_signed_b`.
- **`muldiv_sign`.** One combinational sub-module: operand magnitude and sign extraction, plus the final conditional negate.

## Test plan
- **MUL.** rs1=7, rs2=0xFFFFFFFD; mul unit returns 21 after 1 cycle → `a_o`=7, `b_o`=3, `rd_o`=0xFFFFFFEB, `done_o` pulses once.
- **DIV and REM.** DIV rs1=0xFFFFFFF9, rs2=2; div returns q=3, r=1 → `rd_o`=0xFFFFFFFD. Same operands with REM → 0xFFFFFFFF.
- **Divide by zero.** DIVU 5/0 → no `div_req_o`, `done_o` 2 cycles after valid, `rd_o`=0xFFFFFFFF. REM 5/0 → `rd_o`=5.
- **Signed overflow.** DIV 0x80000000/0xFFFFFFFF → no request, `rd_o`=0x80000000. REM with the same operands → 0.
- **Slow unit.** Hold `mul_ready_i` low for 5 cycles with MULHU 0xFFFFFFFF×2 → `mul_req_o`, `a_o`, `b_o` and `stall_o` stable throughout. Ready with result 0x1_FFFFFFFE → `rd_o`=1 one cycle later.
- **Reset and flush in REQ.** Assert `rst_i` (and separately `flush_i`) in REQ, then a late ready → all outputs 0, state IDLE, no `done_o`. The next instruction completes normally.
